// File: rtl/spi_slave_if_if.sv
// spi_slave_if_if
//   SPI-side and RAM-side signal bundle for spi_slave_if.
//   slave modport  : view of the SPI slave front-end (spi_slave_if).
//   master modport : view of the SPI master / RAM model driving it.
//   Signals: SS_n, MOSI, MISO, rx_data[9:0], rx_valid, tx_data[7:0], tx_valid,
//            frame_err (only when SPI_SLAVE_IF_FRAME_ERR_EN is defined).
interface spi_slave_if_if;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
  logic       frame_err;

  modport slave  (input SS_n, MOSI, tx_data, tx_valid,
                  output MISO, rx_data, rx_valid, frame_err);
  modport master (output SS_n, MOSI, tx_data, tx_valid,
                  input MISO, rx_data, rx_valid, frame_err);
`else
  modport slave  (input SS_n, MOSI, tx_data, tx_valid,
                  output MISO, rx_data, rx_valid);
  modport master (output SS_n, MOSI, tx_data, tx_valid,
                  input MISO, rx_data, rx_valid);
`endif
endinterface

// File: rtl/spi_slave_if.sv
// spi_slave_if
//   SPI slave front-end for the single-port RAM. Deserialises MOSI frames
//   (mode bit + 10-bit {cmd,byte} word) into rx_data/rx_valid and, for
//   read-data frames, serialises the RAM's tx_data back onto MISO, MSB first.
//   clk doubles as the SPI clock: one bit per rising edge while SS_n is low.
//
// Ports
//   clk  : system clock / SCK, rising edge
//   rst  : synchronous active-high reset
//   bus  : spi_slave_if_if.slave (SS_n, MOSI, MISO, rx_data, rx_valid,
//          tx_data, tx_valid, and frame_err when enabled)
//
// Build option
//   SPI_SLAVE_IF_FRAME_ERR_EN : adds bus.frame_err, a one-cycle pulse when
//   a frame is aborted by SS_n before rx_valid or while MISO is shifting.
//
// States
//   IDLE      | waiting for SS_n low
//   CHK_CMD   | sampling the mode bit (0 = write, 1 = read)
//   WRITE     | receiving a write address/data word
//   READ_ADD  | receiving a read address word; sets rd_addr_seen
//   READ_DATA | receiving the read-data word, then shifting tx_data on MISO
module spi_slave_if #(
  parameter int DATA_W = 10   // fixed by the RAM command format {cmd[1:0], byte[7:0]}
) (
  input  logic          clk,
  input  logic          rst,
  spi_slave_if_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;       // data bits still to receive, minus one
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_done_q, rx_done_d;       // full word received this frame
  logic              rd_addr_seen_q, rd_addr_seen_d;
  logic              captured_q, captured_d;     // tx_data already taken this frame
  logic              shifting_q, shifting_d;     // MISO serialisation in progress
  logic [2:0]        tx_cnt_q, tx_cnt_d;         // MISO bits still to drive
  logic [6:0]        tx_shift_q, tx_shift_d;
  logic              miso_q, miso_d;
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
  logic              frame_err_q, frame_err_d;
`endif

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_done_d      = rx_done_q;
    rd_addr_seen_d = rd_addr_seen_q;
    captured_d     = captured_q;
    shifting_d     = shifting_q;
    tx_cnt_d       = tx_cnt_q;
    tx_shift_d     = tx_shift_q;
    miso_d         = miso_q;
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
    frame_err_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!bus.SS_n) state_d = CHK_CMD;
      end

      CHK_CMD: begin
        if (bus.SS_n) begin
          state_d = IDLE;
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
          frame_err_d = 1'b1;
`endif
        end else begin
          bit_cnt_d  = 4'(DATA_W - 1);
          rx_done_d  = 1'b0;
          captured_d = 1'b0;
          if (!bus.MOSI)          state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (shifting_q && (tx_cnt_q == 3'd0)) begin
          // Bit 0 already went out on the previous edge: the response is
          // complete, so this edge finishes it even if SS_n is rising now.
          miso_d         = 1'b0;
          shifting_d     = 1'b0;
          rd_addr_seen_d = 1'b0;
          if (bus.SS_n) state_d = IDLE;
        end else if (bus.SS_n) begin
          state_d   = IDLE;
          bit_cnt_d = 4'd0;
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
          if (!rx_done_q || shifting_q) frame_err_d = 1'b1;
`endif
          if (shifting_q) begin
            // Aborted response: rd_addr_seen stays set so the read can be retried.
            shifting_d = 1'b0;
            miso_d     = 1'b0;
            tx_cnt_d   = 3'd0;
          end
        end else if (!rx_done_q) begin
          shift_d = {shift_q[DATA_W-3:0], bus.MOSI};
          if (bit_cnt_q == 4'd0) begin
            rx_data_d  = {shift_q, bus.MOSI};
            rx_valid_d = 1'b1;
            rx_done_d  = 1'b1;
            if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end else if (state_q == READ_DATA) begin
          if (shifting_q) begin
            miso_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
            tx_cnt_d   = tx_cnt_q - 3'd1;
          end else if (!captured_q && !rx_valid_q && bus.tx_valid) begin
            // rx_valid_q high means this is the edge right after the pulse,
            // where tx_valid may still be the stale level of a previous read.
            miso_d     = bus.tx_data[7];
            tx_shift_d = bus.tx_data[6:0];
            tx_cnt_d   = 3'd7;
            shifting_d = 1'b1;
            captured_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_done_q      <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      captured_q     <= 1'b0;
      shifting_q     <= 1'b0;
      tx_cnt_q       <= '0;
      tx_shift_q     <= '0;
      miso_q         <= 1'b0;
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
      frame_err_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_done_q      <= rx_done_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      captured_q     <= captured_d;
      shifting_q     <= shifting_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_shift_q     <= tx_shift_d;
      miso_q         <= miso_d;
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
      frame_err_q    <= frame_err_d;
`endif
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
  assign bus.frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
module tb_spi_slave_if;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  spi_slave_if_if bus ();

  spi_slave_if dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge, let one rising edge pass, return at the
  // next falling edge where outputs are stable.
  task automatic step(input logic ss, input logic mosi);
    bus.SS_n = ss;
    bus.MOSI = mosi;
    @(posedge clk);
    @(negedge clk);
  endtask

  // E0 .. E11: select, mode bit, ten data bits MSB first.
  task automatic send_frame(input string tag, input logic mode, input logic [9:0] bits);
    step(1'b0, 1'b0);
    step(1'b0, mode);
    for (int i = 9; i >= 1; i--) step(1'b0, bits[i]);
    check({tag, " rx_valid_early"}, 16'(bus.rx_valid), 16'd0);
    step(1'b0, bits[0]);
    check({tag, " rx_valid"}, 16'(bus.rx_valid), 16'd1);
    check({tag, " rx_data"}, 16'(bus.rx_data), 16'(bits));
  endtask

  logic [7:0] exp_byte;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.SS_n    = 1'b1;
    bus.MOSI    = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    @(negedge clk);

    // Reset held for two edges, released with SS_n high.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rst = 1'b0;
    step(1'b1, 1'b0);
    check("rst miso", 16'(bus.MISO), 16'd0);
    check("rst rx_valid", 16'(bus.rx_valid), 16'd0);
    check("rst rx_data", 16'(bus.rx_data), 16'd0);
    check("rst rd_addr_seen", 16'(dut.rd_addr_seen_q), 16'd0);
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
    check("rst frame_err", 16'(bus.frame_err), 16'd0);
`endif

    // Write address and write data frames.
    send_frame("wr_addr", 1'b0, 10'h0A5);
    step(1'b1, 1'b0);
    check("wr_addr pulse_end", 16'(bus.rx_valid), 16'd0);
    send_frame("wr_data", 1'b0, 10'h13C);
    step(1'b1, 1'b0);
    check("wr_data pulse_end", 16'(bus.rx_valid), 16'd0);
    check("wr_data rd_addr_seen", 16'(dut.rd_addr_seen_q), 16'd0);

    // Read address frame.
    send_frame("rd_addr", 1'b1, 10'h2A5);
    check("rd_addr rd_addr_seen", 16'(dut.rd_addr_seen_q), 16'd1);
    step(1'b1, 1'b0);

    // Read data frame; tx_valid is stale-high with old data until the RAM
    // responds at E12 with 0x3C.
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    send_frame("rd_data", 1'b1, 10'h300);
    step(1'b0, 1'b0);                       // E12: stale level ignored
    bus.tx_data = 8'h3C;
    check("rd_data miso_e12", 16'(bus.MISO), 16'd0);
    check("rd_data pulse_end", 16'(bus.rx_valid), 16'd0);
    exp_byte = 8'h3C;
    for (int i = 7; i >= 0; i--) begin      // E13 .. E20
      step(1'b0, 1'b0);
      check("rd_data miso_bit", 16'(bus.MISO), 16'(exp_byte[i]));
    end
    check("rd_data seen_during", 16'(dut.rd_addr_seen_q), 16'd1);
    step(1'b0, 1'b0);                       // E21
    check("rd_data miso_done", 16'(bus.MISO), 16'd0);
    check("rd_data seen_clr", 16'(dut.rd_addr_seen_q), 16'd0);
    step(1'b0, 1'b0);                       // no second capture
    check("rd_data one_capture", 16'(bus.MISO), 16'd0);
    step(1'b1, 1'b0);
    bus.tx_valid = 1'b0;

    // Abort after five data bits.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("abort rx_valid", 16'(bus.rx_valid), 16'd0);
    check("abort rx_data", 16'(bus.rx_data), 16'h300);
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
    check("abort frame_err", 16'(bus.frame_err), 16'd1);
`endif
    step(1'b1, 1'b0);
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
    check("abort frame_err_end", 16'(bus.frame_err), 16'd0);
`endif
    send_frame("after_abort", 1'b0, 10'h3FF);
    step(1'b1, 1'b0);

    // Reset during READ_DATA shifting.
    send_frame("rd_addr2", 1'b1, 10'h155);
    step(1'b1, 1'b0);
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    send_frame("rd_data2", 1'b1, 10'h000);
    step(1'b0, 1'b0);                       // E12
    step(1'b0, 1'b0);                       // E13
    check("rd_data2 miso_b7", 16'(bus.MISO), 16'd1);
    step(1'b0, 1'b0);                       // E14
    check("rd_data2 miso_b6", 16'(bus.MISO), 16'd0);
    rst = 1'b1;
    step(1'b0, 1'b0);
    check("midrst miso", 16'(bus.MISO), 16'd0);
    check("midrst rd_addr_seen", 16'(dut.rd_addr_seen_q), 16'd0);
    check("midrst rx_data", 16'(bus.rx_data), 16'd0);
    rst = 1'b0;
    step(1'b1, 1'b0);
    send_frame("post_rst", 1'b1, 10'h0F0);
    check("post_rst rd_addr_seen", 16'(dut.rd_addr_seen_q), 16'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("post_rst no_shift", 16'(bus.MISO), 16'd0);
    step(1'b1, 1'b0);

    // Abort while MISO is shifting; rd_addr_seen must survive for a retry.
    bus.tx_data = 8'h81;
    send_frame("rd_data3", 1'b1, 10'h001);
    step(1'b0, 1'b0);                       // E12
    step(1'b0, 1'b0);                       // E13
    check("rd_data3 miso_b7", 16'(bus.MISO), 16'd1);
    step(1'b1, 1'b0);
    check("shift_abort miso", 16'(bus.MISO), 16'd0);
    check("shift_abort rd_addr_seen", 16'(dut.rd_addr_seen_q), 16'd1);
`ifdef SPI_SLAVE_IF_FRAME_ERR_EN
    check("shift_abort frame_err", 16'(bus.frame_err), 16'd1);
`endif
    step(1'b1, 1'b0);
    send_frame("retry", 1'b1, 10'h002);
    step(1'b0, 1'b0);                       // E12
    step(1'b0, 1'b0);                       // E13
    check("retry miso_b7", 16'(bus.MISO), 16'd1);
    step(1'b0, 1'b0);                       // E14
    check("retry miso_b6", 16'(bus.MISO), 16'd0);
    step(1'b1, 1'b0);
    bus.tx_valid = 1'b0;
    step(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
